// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction-RAM arbiter: boot sequencing states and response ownership.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } boot_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_IF   = 2'd2
  } owner_e;

  localparam int unsigned RAM_LATENCY = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; index 0 = loader, index 1 = fetch.
// On contention the requester that did not win last time gets the grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn_i,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // High when requester 1 holds the most recent grant (reset favours requester 0)
  logic rr_last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_last_q <= 1'b1;
    end else if (gnt[0]) begin
      rr_last_q <= 1'b0;
    end else if (gnt[1]) begin
      rr_last_q <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Shares the single-port instruction RAM between the loader/debug port and core fetch,
// holding the core in reset until the loader signals completion.
module instr_mem_arbiter
  import instr_mem_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 8,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  load_done_i,
  input  logic                  boot_hold_i,
  input  logic                  ld_req_i,
  input  logic                  ld_we_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [DATA_WIDTH-1:0] ld_wdata_i,
  input  logic [BE_WIDTH-1:0]   ld_be_i,
  output logic                  ld_gnt_o,
  output logic                  ld_rvalid_o,
  output logic [DATA_WIDTH-1:0] ld_rdata_o,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  core_rstn_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [BE_WIDTH-1:0]   ram_be_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  if (DATA_WIDTH != 32 || RAM_LATENCY != 1) begin : g_bad_cfg
    $error("instr_mem_arbiter supports only 32-bit data and a 1-cycle RAM");
  end

  boot_state_e state_q, state_d;
  owner_e      resp_owner_q, resp_owner_d;
  logic        core_rstn_q, core_rstn_d;
  logic [1:0]  arb_req;
  logic [1:0]  arb_gnt;
  logic        arb_en;

  // Fetch is only eligible in RUN; nobody is granted while draining
  assign arb_req = {if_req_i & (state_q == RUN), ld_req_i & (state_q != DRAIN)};
  assign arb_en  = (state_q != DRAIN);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rstn_i (rstn_i),
    .req    (arb_req),
    .en     (arb_en),
    .gnt    (arb_gnt)
  );

  assign ld_gnt_o = arb_gnt[0];
  assign if_gnt_o = arb_gnt[1];

  // Boot sequencing and registered core reset release
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (!boot_hold_i && load_done_i) state_d = RUN;
      RUN:     if (boot_hold_i) state_d = DRAIN;
      // With a 1-cycle RAM the last grant's response retires during this cycle
      DRAIN:   state_d = BOOT;
      default: state_d = BOOT;
    endcase
    core_rstn_d = (state_d != BOOT);
  end

  always_comb begin
    resp_owner_d = OWN_NONE;
    if (ld_gnt_o) begin
      resp_owner_d = OWN_LD;
    end else if (if_gnt_o) begin
      resp_owner_d = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= BOOT;
      resp_owner_q <= OWN_NONE;
      core_rstn_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_owner_q <= resp_owner_d;
      core_rstn_q  <= core_rstn_d;
    end
  end

  // RAM port mux: fetch is a full-word read, otherwise loader fields pass through
  always_comb begin
    ram_en_o    = ld_gnt_o | if_gnt_o;
    ram_we_o    = ld_gnt_o & ld_we_i;
    ram_addr_o  = ld_addr_i;
    ram_wdata_o = ld_wdata_i;
    ram_be_o    = ld_be_i;
    if (if_gnt_o) begin
      ram_addr_o  = if_addr_i;
      ram_wdata_o = '0;
      ram_be_o    = '1;
    end
  end

  assign ld_rvalid_o = (resp_owner_q == OWN_LD);
  assign if_rvalid_o = (resp_owner_q == OWN_IF);
  assign ld_rdata_o  = ram_rdata_i;
  assign if_rdata_o  = ram_rdata_i;
  assign core_rstn_o = core_rstn_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter with a per-cycle behavioural model and a RAM model.
module tb_instr_mem_arbiter;

  logic        clk;
  logic        rstn_i;
  logic        load_done_i, boot_hold_i;
  logic        ld_req_i, ld_we_i;
  logic [7:0]  ld_addr_i;
  logic [31:0] ld_wdata_i;
  logic [3:0]  ld_be_i;
  logic        ld_gnt_o, ld_rvalid_o;
  logic [31:0] ld_rdata_o;
  logic        if_req_i;
  logic [7:0]  if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        core_rstn_o;
  logic        ram_en_o, ram_we_o;
  logic [7:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_rdata_i;

  int errors = 0;
  int checks = 0;

  instr_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .load_done_i (load_done_i),
    .boot_hold_i (boot_hold_i),
    .ld_req_i    (ld_req_i),
    .ld_we_i     (ld_we_i),
    .ld_addr_i   (ld_addr_i),
    .ld_wdata_i  (ld_wdata_i),
    .ld_be_i     (ld_be_i),
    .ld_gnt_o    (ld_gnt_o),
    .ld_rvalid_o (ld_rvalid_o),
    .ld_rdata_o  (ld_rdata_o),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .core_rstn_o (core_rstn_o),
    .ram_en_o    (ram_en_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_be_o    (ram_be_o),
    .ram_rdata_i (ram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RAM model: 64 words, byte-enabled writes, read data one cycle after enable
  logic [31:0] ram_mem [64];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[7:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
      ram_rdata_i <= ram_mem[ram_addr_o[7:2]];
    end
  end

  // Behavioural model: phase 0=boot, 1=run, 2=drain; pend 0=none, 1=loader, 2=fetch
  logic [31:0] ref_mem [64];
  int          m_phase;
  int          m_pend;
  logic        m_pend_rd;
  logic [31:0] m_pend_data;
  logic        m_fetch_won_last;
  logic        m_core;
  logic        ld_ok, if_ok, e_ld, e_if;

  always @(negedge clk) begin
    if (!rstn_i) begin
      m_phase = 0; m_pend = 0; m_fetch_won_last = 1'b1; m_core = 1'b0;
    end
    ld_ok = ld_req_i && (m_phase != 2);
    if_ok = if_req_i && (m_phase == 1);
    e_ld  = ld_ok && (!if_ok || m_fetch_won_last);
    e_if  = if_ok && !e_ld;

    chk("ld_gnt", 32'(ld_gnt_o), 32'(e_ld));
    chk("if_gnt", 32'(if_gnt_o), 32'(e_if));
    chk("ram_en", 32'(ram_en_o), 32'(e_ld || e_if));
    chk("core_rstn", 32'(core_rstn_o), 32'(m_core));
    chk("ld_rvalid", 32'(ld_rvalid_o), 32'(m_pend == 1));
    chk("if_rvalid", 32'(if_rvalid_o), 32'(m_pend == 2));
    if (m_pend == 1 && m_pend_rd) chk("ld_rdata", ld_rdata_o, m_pend_data);
    if (m_pend == 2) chk("if_rdata", if_rdata_o, m_pend_data);
    if (e_ld) begin
      chk("ram_addr_ld", 32'(ram_addr_o), 32'(ld_addr_i));
      chk("ram_we_ld", 32'(ram_we_o), 32'(ld_we_i));
      chk("ram_be_ld", 32'(ram_be_o), 32'(ld_be_i));
      if (ld_we_i) chk("ram_wdata_ld", ram_wdata_o, ld_wdata_i);
    end
    if (e_if) begin
      chk("ram_addr_if", 32'(ram_addr_o), 32'(if_addr_i));
      chk("ram_we_if", 32'(ram_we_o), 32'h0);
      chk("ram_be_if", 32'(ram_be_o), 32'hF);
    end

    if (rstn_i) begin
      m_pend = 0;
      if (e_ld) begin
        m_pend = 1; m_pend_rd = !ld_we_i;
        m_pend_data = ref_mem[ld_addr_i[7:2]];
        if (ld_we_i)
          for (int b = 0; b < 4; b++)
            if (ld_be_i[b]) ref_mem[ld_addr_i[7:2]][8*b +: 8] = ld_wdata_i[8*b +: 8];
        m_fetch_won_last = 1'b0;
      end else if (e_if) begin
        m_pend = 2; m_pend_rd = 1'b1;
        m_pend_data = ref_mem[if_addr_i[7:2]];
        m_fetch_won_last = 1'b1;
      end
      if (m_phase == 0 && load_done_i && !boot_hold_i) m_phase = 1;
      else if (m_phase == 1 && boot_hold_i) m_phase = 2;
      else if (m_phase == 2) m_phase = 0;
      m_core = (m_phase != 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    ram_rdata_i = '0;
    rstn_i = 1'b0; load_done_i = 1'b0; boot_hold_i = 1'b0;
    ld_req_i = 1'b0; ld_we_i = 1'b0; ld_addr_i = '0; ld_wdata_i = '0; ld_be_i = '0;
    if_req_i = 1'b0; if_addr_i = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_core_rstn", 32'(core_rstn_o), 32'h0);
    chk("rst_ld_rvalid", 32'(ld_rvalid_o), 32'h0);
    step();
    rstn_i = 1'b1;

    // Boot: loader write is granted, fetch is ignored
    ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 8'h04; ld_wdata_i = 32'h0000_0013; ld_be_i = 4'hF;
    if_req_i = 1'b1; if_addr_i = 8'h04;
    @(negedge clk);
    chk("t1_ld_gnt", 32'(ld_gnt_o), 32'h1);
    chk("t1_if_gnt", 32'(if_gnt_o), 32'h0);
    step();
    ld_req_i = 1'b0;
    @(negedge clk);
    chk("t1_ld_rvalid", 32'(ld_rvalid_o), 32'h1);
    chk("t1_if_gnt_held", 32'(if_gnt_o), 32'h0);
    chk("t1_core_rstn", 32'(core_rstn_o), 32'h0);
    step();

    // Release core, then fetch the word just written
    if_req_i = 1'b0; load_done_i = 1'b1;
    step();
    load_done_i = 1'b0; if_req_i = 1'b1; if_addr_i = 8'h04;
    @(negedge clk);
    chk("t2_core_rstn", 32'(core_rstn_o), 32'h1);
    chk("t2_if_gnt", 32'(if_gnt_o), 32'h1);
    step();
    if_req_i = 1'b0;
    @(negedge clk);
    chk("t2_if_rvalid", 32'(if_rvalid_o), 32'h1);
    chk("t2_if_rdata", if_rdata_o, 32'h0000_0013);
    step();

    // Continuous contention alternates, loader first
    ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 8'h08; if_req_i = 1'b1; if_addr_i = 8'h04;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_ld_gnt", 32'(ld_gnt_o), 32'(i % 2 == 0));
      chk("t3_if_gnt", 32'(if_gnt_o), 32'(i % 2 == 1));
      if (i > 0) chk("t3_ld_rvalid", 32'(ld_rvalid_o), 32'((i - 1) % 2 == 0));
      step();
    end
    ld_req_i = 1'b0; if_req_i = 1'b0;
    @(negedge clk);
    chk("t3_if_rvalid_last", 32'(if_rvalid_o), 32'h1);
    step();

    // Single-byte write then read-back
    ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 8'h04; ld_wdata_i = 32'hAABB_CCDD; ld_be_i = 4'b0100;
    step();
    ld_we_i = 1'b0; ld_be_i = 4'hF;
    step();
    ld_req_i = 1'b0;
    @(negedge clk);
    chk("t4_ld_rvalid", 32'(ld_rvalid_o), 32'h1);
    chk("t4_ld_rdata", ld_rdata_o, 32'h00BB_0013);
    step();

    // boot_hold during a fetch grant: drain delivers the fetch, then back to boot
    if_req_i = 1'b1; if_addr_i = 8'h04; boot_hold_i = 1'b1;
    @(negedge clk);
    chk("t5_if_gnt", 32'(if_gnt_o), 32'h1);
    step();
    @(negedge clk);
    chk("t5_drain_if_gnt", 32'(if_gnt_o), 32'h0);
    chk("t5_drain_if_rvalid", 32'(if_rvalid_o), 32'h1);
    chk("t5_drain_if_rdata", if_rdata_o, 32'h00BB_0013);
    step();
    @(negedge clk);
    chk("t5_boot_core_rstn", 32'(core_rstn_o), 32'h0);
    chk("t5_boot_if_gnt", 32'(if_gnt_o), 32'h0);
    load_done_i = 1'b1;
    step();
    load_done_i = 1'b0;
    @(negedge clk);
    chk("t5_hold_beats_done", 32'(core_rstn_o), 32'h0);
    boot_hold_i = 1'b0; if_req_i = 1'b0;
    step();

    // Reset in the cycle after a loader grant drops the response
    load_done_i = 1'b1;
    step();
    load_done_i = 1'b0; ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 8'h04;
    step();
    ld_req_i = 1'b0; rstn_i = 1'b0;
    @(negedge clk);
    chk("t6_ld_rvalid", 32'(ld_rvalid_o), 32'h0);
    chk("t6_core_rstn", 32'(core_rstn_o), 32'h0);
    repeat (2) step();
    rstn_i = 1'b1;
    if_req_i = 1'b1;
    @(negedge clk);
    chk("t6_boot_if_gnt", 32'(if_gnt_o), 32'h0);
    chk("t6_boot_core", 32'(core_rstn_o), 32'h0);
    step();
    if_req_i = 1'b0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
